// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory model; request on rwToMem/addrToMem/dataToMem, one-cycle rdEn/wtEn acknowledge, dataFromMem read data, busy in BUSY/DONE, sticky addrErr for addresses >= DEPTH
module mem_responder #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int DEPTH = 256,
  parameter int LATENCY = 3,
  parameter int IOSTATEWIDTH = 2,
  parameter logic [IOSTATEWIDTH-1:0] IDEL = '0,
  parameter logic [IOSTATEWIDTH-1:0] RD = IOSTATEWIDTH'(1),
  parameter logic [IOSTATEWIDTH-1:0] WT = IOSTATEWIDTH'(2)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwToMem,
  input  logic [ADDR_W-1:0]       addrToMem,
  input  logic [WORD_W-1:0]       dataToMem,
  output logic                    rdEn,
  output logic                    wtEn,
  output logic [WORD_W-1:0]       dataFromMem,
  output logic                    busy,
  output logic                    addrErr
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int XW = ADDR_W > 32 ? ADDR_W : 32;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t state, state_n;
  logic [IOSTATEWIDTH-1:0] req, op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic [CW-1:0] cnt;
  logic [WORD_W-1:0] mem [DEPTH];
  logic capture, fire, hold, in_range;
  logic [IW-1:0] idx;
  assign busy = state == S_BUSY || state == S_DONE;
  assign idx = addr_q[IW-1:0];
  assign in_range = XW'(addr_q) < XW'(DEPTH);
  always_comb begin
    req = (rwToMem == RD || rwToMem == WT) ? rwToMem : IDEL;
    capture = state == S_IDLE && req != IDEL;
    hold = state == S_BUSY && req == op_q;
    fire = hold && cnt == '0;
    state_n = capture ? S_BUSY :
              fire ? S_DONE :
              hold ? S_BUSY :
              (state == S_DONE && req != IDEL) ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      rdEn <= 1'b0;
      wtEn <= 1'b0;
      dataFromMem <= '0;
      addrErr <= 1'b0;
      op_q <= IDEL;
      addr_q <= '0;
      data_q <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rdEn <= fire && op_q == RD;
      wtEn <= fire && op_q == WT;
      if (capture) begin
        op_q <= req;
        addr_q <= addrToMem;
        data_q <= dataToMem;
        cnt <= CW'(LATENCY - 1);
      end else if (hold && cnt != '0) cnt <= cnt - 1'b1;
      if (fire) begin
        addrErr <= addrErr | ~in_range;
        if (op_q == RD) dataFromMem <= in_range ? mem[idx] : '0;
        if (op_q == WT && in_range) mem[idx] <= data_q;
      end
    end
endmodule
